// File: rtl/cache_req_sequencer_pkg.sv
// rtl/cache_req_sequencer_pkg.sv - shared types and constants for the cache request sequencer
package cache_seq_pkg;

    localparam int CSQ_DATA_WIDTH = 32;
    localparam int CSQ_TAG_WIDTH  = 8;
    localparam int STAT_WIDTH     = 16;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } seq_state_t;

    typedef struct packed {
        logic [CSQ_DATA_WIDTH-1:0] data;
        logic                      hit;
        logic [CSQ_TAG_WIDTH-1:0]  tag;
    } rsp_rec_t;

    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
        return (v == '1) ? v : v + STAT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/cache_req_sequencer_seq_queue.sv
// rtl/cache_req_sequencer_seq_queue.sv - synchronous FIFO with wrap-around pointers and clear
module seq_queue #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      pop_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [ADDR_WIDTH:0] wr_ptr;
    logic [ADDR_WIDTH:0] rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                     (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    assign do_pop  = pop && !empty;
    // a pop frees the slot in the same cycle, so a full queue can still take a push
    assign do_push = push && (!full || do_pop);

    // head reads as zero while empty so nothing stale leaks onto the outputs
    assign pop_data = empty ? '0 : mem[rd_ptr[ADDR_WIDTH-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr[ADDR_WIDTH-1:0]] <= push_data;
    end

endmodule

// File: rtl/cache_req_sequencer.sv
// rtl/cache_req_sequencer.sv - credit-limited lookup sequencer for the cache FIFO (optional stats: CACHE_REQ_SEQ_STATS_EN)
module cache_req_sequencer
    import cache_seq_pkg::*;
#(
    parameter int DATA_WIDTH     = CSQ_DATA_WIDTH,
    parameter int TAG_WIDTH      = CSQ_TAG_WIDTH,
    parameter int REQ_ADDR_WIDTH = 2,
    parameter int RSP_ADDR_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [TAG_WIDTH-1:0]  req_tag,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_hit,
    output logic [TAG_WIDTH-1:0]  rsp_tag,
    input  logic                  rsp_ready,
    output logic                  rd_en,
    output logic [TAG_WIDTH-1:0]  rd_tag,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_valid,
    input  logic                  rd_hit,
    input  logic                  cache_empty,
    input  logic                  flush,
    output logic                  flush_done,
    output logic                  busy
`ifdef CACHE_REQ_SEQ_STATS_EN
    ,
    input  logic                  clear_stats,
    output logic [STAT_WIDTH-1:0] hit_count,
    output logic [STAT_WIDTH-1:0] miss_count
`endif
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  hit;
        logic [TAG_WIDTH-1:0]  tag;
    } rsp_t;

    localparam int RSP_W = $bits(rsp_t);
    localparam logic [RSP_ADDR_WIDTH+1:0] RSP_DEPTH = (RSP_ADDR_WIDTH+2)'(1 << RSP_ADDR_WIDTH);

    seq_state_t                state_q, state_d;
    logic                      inflight_q;
    logic [TAG_WIDTH-1:0]      issued_tag_q;

    logic                      req_push, req_clear, req_full, req_empty;
    logic [REQ_ADDR_WIDTH:0]   req_count;
    logic [TAG_WIDTH-1:0]      req_head;

    logic                      rsp_pop, rsp_full, rsp_empty;
    logic [RSP_ADDR_WIDTH:0]   rsp_count;
    rsp_t                      rsp_in, rsp_out;
    logic [RSP_ADDR_WIDTH+1:0] rsp_used;
    logic                      credit_ok;

    seq_queue #(.WIDTH(TAG_WIDTH), .ADDR_WIDTH(REQ_ADDR_WIDTH)) u_req_q (
        .clk       (clk),
        .rst       (rst),
        .clear     (req_clear),
        .push      (req_push),
        .push_data (req_tag),
        .pop       (rd_en),
        .pop_data  (req_head),
        .count     (req_count),
        .full      (req_full),
        .empty     (req_empty)
    );

    seq_queue #(.WIDTH(RSP_W), .ADDR_WIDTH(RSP_ADDR_WIDTH)) u_rsp_q (
        .clk       (clk),
        .rst       (rst),
        .clear     (1'b0),
        .push      (rd_valid),
        .push_data (rsp_in),
        .pop       (rsp_pop),
        .pop_data  (rsp_out),
        .count     (rsp_count),
        .full      (rsp_full),
        .empty     (rsp_empty)
    );

    // a read may only issue if its response is guaranteed a slot even if nothing drains
    assign rsp_used  = {1'b0, rsp_count} + {{(RSP_ADDR_WIDTH+1){1'b0}}, inflight_q};
    assign credit_ok = rsp_used < RSP_DEPTH;

    assign req_push  = req_valid && req_ready;
    assign rd_tag    = req_head;
    assign rsp_in    = '{data: rd_data, hit: rd_hit, tag: issued_tag_q};
    assign rsp_valid = !rsp_empty;
    assign rsp_pop   = rsp_valid && rsp_ready;
    assign rsp_data  = rsp_out.data;
    assign rsp_hit   = rsp_out.hit;
    assign rsp_tag   = rsp_out.tag;
    assign busy      = (req_count != '0) || inflight_q;

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        rd_en      = 1'b0;
        req_clear  = 1'b0;
        flush_done = 1'b0;
        unique case (state_q)
            RUN: begin
                req_ready = !req_full;
                rd_en     = !req_empty && !cache_empty && credit_ok;
                if (flush) state_d = FLUSH;
            end
            FLUSH: begin
                // wait for the outstanding return, then drop whatever is still queued
                if (!inflight_q) begin
                    req_clear  = 1'b1;
                    flush_done = 1'b1;
                    state_d    = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            inflight_q   <= 1'b0;
            issued_tag_q <= '0;
        end else begin
            state_q <= state_d;
            if (rd_en) begin
                inflight_q   <= 1'b1;
                issued_tag_q <= rd_tag;
            end else if (rd_valid) begin
                inflight_q   <= 1'b0;
            end
        end
    end

`ifdef CACHE_REQ_SEQ_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (clear_stats) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (rd_valid) begin
            if (rd_hit) hit_count  <= sat_inc(hit_count);
            else        miss_count <= sat_inc(miss_count);
        end
    end
`endif

    a_rsp_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(rd_valid && rsp_full && !rsp_pop));

endmodule

// File: tb/tb_cache_req_sequencer.sv
// tb/tb_cache_req_sequencer.sv - randomized bench with a queue-level reference model
module tb_cache_req_sequencer;
    import cache_seq_pkg::*;

    localparam int DW = 32;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready;
    logic [TW-1:0] req_tag;
    logic          rsp_valid, rsp_hit, rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [TW-1:0] rsp_tag;
    logic          rd_en, rd_valid, rd_hit, cache_empty, flush, flush_done, busy;
    logic [TW-1:0] rd_tag;
    logic [DW-1:0] rd_data;
`ifdef CACHE_REQ_SEQ_STATS_EN
    logic          clear_stats;
    logic [15:0]   hit_count, miss_count;
`endif

    cache_req_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_tag     (req_tag),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_hit     (rsp_hit),
        .rsp_tag     (rsp_tag),
        .rsp_ready   (rsp_ready),
        .rd_en       (rd_en),
        .rd_tag      (rd_tag),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_hit      (rd_hit),
        .cache_empty (cache_empty),
        .flush       (flush),
        .flush_done  (flush_done),
        .busy        (busy)
`ifdef CACHE_REQ_SEQ_STATS_EN
        ,
        .clear_stats (clear_stats),
        .hit_count   (hit_count),
        .miss_count  (miss_count)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference model: accepted tags, outstanding read, undelivered responses
    logic [TW-1:0] m_req[$];
    rsp_rec_t      m_rsp[$];
    bit            m_inflight, m_flushing;
    logic [TW-1:0] m_itag;

    logic [DW-1:0] data_mem[256];
    logic          hit_mem[256];
    bit            pend, force_rd, checking;
    logic [TW-1:0] pend_tag;
    int            cyc_n = 0, rd_seen = 0, rsp_seen = 0;
    int            acc_cyc, first_rd_cyc, first_rsp_cyc;

    always @(negedge clk) begin
        bit exp_ready, exp_rd, exp_busy, exp_done, exp_valid;
        rsp_rec_t r;
        cyc_n++;
        pend     = rd_en && !rst;
        pend_tag = rd_tag;
        if (rd_en) rd_seen++;
        if (rsp_valid && rsp_ready) rsp_seen++;
        if (rd_en && first_rd_cyc < 0) first_rd_cyc = cyc_n;
        if (rsp_valid && first_rsp_cyc < 0) first_rsp_cyc = cyc_n;
        if (rst) begin
            m_req.delete();
            m_rsp.delete();
            m_inflight = 0;
            m_flushing = 0;
        end else if (checking) begin
            exp_ready = !m_flushing && m_req.size() < 4;
            exp_rd    = !m_flushing && m_req.size() > 0 && !cache_empty &&
                        (m_rsp.size() + (m_inflight ? 1 : 0) < 2);
            exp_busy  = m_req.size() > 0 || m_inflight;
            exp_done  = m_flushing && !m_inflight;
            exp_valid = m_rsp.size() > 0;
            check_eq("req_ready", req_ready, exp_ready);
            check_eq("rd_en", rd_en, exp_rd);
            check_eq("busy", busy, exp_busy);
            check_eq("flush_done", flush_done, exp_done);
            check_eq("rsp_valid", rsp_valid, exp_valid);
            if (exp_rd) check_eq("rd_tag", rd_tag, m_req[0]);
            if (exp_valid) begin
                check_eq("rsp_data", rsp_data, m_rsp[0].data);
                check_eq("rsp_hit", rsp_hit, m_rsp[0].hit);
                check_eq("rsp_tag", rsp_tag, m_rsp[0].tag);
            end
            if (exp_valid && rsp_ready) void'(m_rsp.pop_front());
            if (rd_valid) begin
                r.data = data_mem[m_itag];
                r.hit  = hit_mem[m_itag];
                r.tag  = m_itag;
                m_rsp.push_back(r);
            end
            if (exp_rd) begin
                m_itag     = m_req.pop_front();
                m_inflight = 1;
            end else if (rd_valid) begin
                m_inflight = 0;
            end
            if (req_valid && exp_ready) begin
                m_req.push_back(req_tag);
                if (acc_cyc < 0) acc_cyc = cyc_n;
            end
            if (exp_done) begin
                m_req.delete();
                m_flushing = 0;
            end else if (!m_flushing && flush) begin
                m_flushing = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (force_rd) begin
            rd_valid = 1'b1;
            rd_hit   = 1'b1;
            rd_data  = $urandom;
        end else begin
            rd_valid = pend;
            rd_data  = pend ? data_mem[pend_tag] : $urandom;
            rd_hit   = pend ? hit_mem[pend_tag] : 1'($urandom);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // holds req_valid with this tag until the sequencer takes it
    task automatic send(input logic [TW-1:0] t);
        bit ok;
        int guard;
        req_valid = 1'b1;
        req_tag   = t;
        guard     = 0;
        do begin
            ok = req_ready;
            tick();
            guard++;
        end while (!ok && guard < 50);
        if (!ok) check_eq("send_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        int rd0, rsp0;
        rst = 1'b1; req_valid = 0; req_tag = '0; rsp_ready = 1'b1; cache_empty = 1'b0;
        flush = 1'b0; rd_valid = 1'b0; rd_data = '0; rd_hit = 1'b0;
        force_rd = 0; checking = 1; pend = 0;
        acc_cyc = -1; first_rd_cyc = -1; first_rsp_cyc = -1;
`ifdef CACHE_REQ_SEQ_STATS_EN
        clear_stats = 1'b0;
`endif
        for (int i = 0; i < 256; i++) begin
            data_mem[i] = $urandom;
            hit_mem[i]  = 1'($urandom);
        end
        do_reset();
        #2;
        check_eq("rst_req_ready", req_ready, 1'b1);
        check_eq("rst_rsp_valid", rsp_valid, 1'b0);
        check_eq("rst_rsp_data", rsp_data, '0);
        check_eq("rst_rsp_hit", rsp_hit, 1'b0);
        check_eq("rst_rsp_tag", rsp_tag, '0);
        check_eq("rst_rd_en", rd_en, 1'b0);
        check_eq("rst_rd_tag", rd_tag, '0);
        check_eq("rst_flush_done", flush_done, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        tick();

        // single lookup latency
        data_mem[8'h3C] = 32'hDEADBEEF;
        hit_mem[8'h3C]  = 1'b1;
        acc_cyc = -1; first_rd_cyc = -1; first_rsp_cyc = -1;
        req_valid = 1'b1; req_tag = 8'h3C;
        tick();
        req_valid = 1'b0;
        repeat (6) tick();
        check_eq("single_rd_latency", 64'(first_rd_cyc - acc_cyc), 64'd1);
        check_eq("single_rsp_latency", 64'(first_rsp_cyc - acc_cyc), 64'd3);

        // back-to-back burst
        rd0 = rd_seen; rsp0 = rsp_seen;
        for (int i = 0; i < 8; i++) send(8'($urandom));
        req_valid = 1'b0;
        repeat (25) tick();
        check_eq("burst_reads", 64'(rd_seen - rd0), 64'd8);
        check_eq("burst_rsps", 64'(rsp_seen - rsp0), 64'd8);

        // consumer stalled: credit caps issue at two reads
        rsp_ready = 1'b0;
        rd0 = rd_seen; rsp0 = rsp_seen;
        for (int i = 0; i < 6; i++) send(8'($urandom));
        req_valid = 1'b0;
        repeat (5) tick();
        check_eq("stall_reads", 64'(rd_seen - rd0), 64'd2);
        check_eq("stall_req_ready", req_ready, 1'b0);
        rsp_ready = 1'b1;
        repeat (30) tick();
        check_eq("stall_rsps", 64'(rsp_seen - rsp0), 64'd6);

        // flush right after one issue with three requests left behind
        rsp0 = rsp_seen;
        cache_empty = 1'b1;
        for (int i = 0; i < 4; i++) send(8'($urandom));
        req_valid = 1'b0;
        cache_empty = 1'b0;
        tick();
        cache_empty = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("flush_done_pulse", flush_done, 1'b1);
        tick();
        check_eq("flush_done_clear", flush_done, 1'b0);
        check_eq("flush_busy", busy, 1'b0);
        check_eq("flush_req_ready", req_ready, 1'b1);
        cache_empty = 1'b0;
        send(8'hA5);
        send(8'h5A);
        req_valid = 1'b0;
        repeat (10) tick();
        check_eq("flush_rsps", 64'(rsp_seen - rsp0), 64'd3);

        // cache empty blocks issue
        rd0 = rd_seen;
        cache_empty = 1'b1;
        send(8'h11);
        send(8'h22);
        req_valid = 1'b0;
        repeat (4) tick();
        check_eq("empty_no_reads", 64'(rd_seen - rd0), 64'd0);
        cache_empty = 1'b0;
        repeat (10) tick();
        check_eq("empty_then_reads", 64'(rd_seen - rd0), 64'd2);

        // random traffic with a mid-run reset
        for (int i = 0; i < 400; i++) begin
            req_valid   = 1'($urandom);
            req_tag     = 8'($urandom);
            rsp_ready   = ($urandom_range(0, 3) != 0);
            cache_empty = ($urandom_range(0, 7) == 0);
            flush       = ($urandom_range(0, 39) == 0);
            if (i == 200) begin
                do_reset();
                #2;
                check_eq("midrst_busy", busy, 1'b0);
                check_eq("midrst_rsp_valid", rsp_valid, 1'b0);
            end
            tick();
        end
        req_valid = 1'b0; flush = 1'b0; cache_empty = 1'b0; rsp_ready = 1'b1;
        repeat (20) tick();
        check_eq("drain_busy", busy, 1'b0);
        check_eq("drain_rsp_valid", rsp_valid, 1'b0);

`ifdef CACHE_REQ_SEQ_STATS_EN
        do_reset();
        for (int i = 1; i <= 5; i++) hit_mem[i] = (i <= 3);
        for (int i = 1; i <= 5; i++) send(8'(i));
        req_valid = 1'b0;
        repeat (15) tick();
        check_eq("stats_hits", hit_count, 16'd3);
        check_eq("stats_misses", miss_count, 16'd2);
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        check_eq("stats_clr_hits", hit_count, 16'd0);
        check_eq("stats_clr_misses", miss_count, 16'd0);
        checking = 0;
        force_rd = 1;
        repeat (65540) tick();
        force_rd = 0;
        tick();
        check_eq("stats_saturate", hit_count, 16'hFFFF);
        check_eq("stats_sat_miss", miss_count, 16'd0);
        do_reset();
        checking = 1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
